square_check: RTL and testbench

- Iterative shift-add squarer that checks a candidate integer square root. It takes a root `r` (same signed width the square-root block emits) and a target `x`.
- Computes `r*r` sequentially and flags whether `r` is the floor square root of `x`, i.e. r^2 <= x < (r+1)^2, using |r|.
- Sits downstream of the square-root unit in the fetal ECG processing path, as its bench/runtime cross-check, with a start/valid handshake.

---
 rtl/square_check_if.sv | 36 +++
 rtl/square_check.sv | 138 +++++++++++++
 tb/tb_square_check.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/square_check_if.sv
// rtl/square_check_if.sv - start/valid handshake bundle between a root source and the squarer check
interface square_check_if #(
  parameter int N_BITS = 32
);

  localparam int RW = N_BITS / 2 + 1;

  logic                     start;
  logic signed [RW-1:0]     root;
  logic signed [N_BITS-1:0] target;
  logic                     busy;
  logic                     valid;
  logic [N_BITS:0]          square;
  logic                     root_ok;

  modport master (
    output start,
    output root,
    output target,
    input  busy,
    input  valid,
    input  square,
    input  root_ok
  );

  modport slave (
    input  start,
    input  root,
    input  target,
    output busy,
    output valid,
    output square,
    output root_ok
  );

endinterface

// File: rtl/square_check.sv
// rtl/square_check.sv - iterative shift-add squarer confirming a candidate floor square root
module square_check #(
  parameter int N_BITS = 32
) (
  input  logic          clk,
  input  logic          rst,
  square_check_if.slave bus
);

  // Root width, iteration count, counter width, square width, compare width
  localparam int RW = N_BITS / 2 + 1;
  localparam int W  = RW;
  localparam int CW = $clog2(W + 1);
  localparam int SW = N_BITS + 1;
  localparam int NW = N_BITS + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   a_q, a_d;
  logic [N_BITS-1:0] tgt_q, tgt_d;
  logic [SW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   sq_q, sq_d;
  logic            ok_q, ok_d;

  logic            accept;
  logic            last;
  logic [RW-1:0]   root_u;
  logic [RW-1:0]   root_abs;
  logic [SW-1:0]   partial;
  logic [SW-1:0]   acc_sum;
  logic [NW-1:0]   next_sq;
  logic [NW-1:0]   tgt_ext;
  logic            ok_calc;

  // Handshake decode and the arithmetic for one multiplier bit
  always_comb begin
    accept   = bus.start && ((state_q == IDLE) || (state_q == DONE));
    last     = (state_q == RUN) && (cnt_q == CW'(W - 1));
    root_u   = $unsigned(bus.root);
    // RW bits hold 2^(N_BITS/2) unsigned, so the most negative root does not wrap
    root_abs = root_u[RW-1] ? (~root_u + RW'(1)) : root_u;
    partial  = a_q[cnt_q] ? (SW'(a_q) << cnt_q) : '0;
    acc_sum  = acc_q + partial;
    // (a+1)^2 = a^2 + 2a + 1, one bit wider so it cannot overflow
    next_sq  = NW'(acc_sum) + (NW'(a_q) << 1) + NW'(1);
    tgt_ext  = NW'(tgt_q);
    ok_calc  = !tgt_q[N_BITS-1] && (NW'(acc_sum) <= tgt_ext) && (next_sq > tgt_ext);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fixed W-cycle run, DONE can re-accept back to back
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = bus.start ? RUN : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath next values: capture on accept, accumulate in RUN, publish on the last bit
  always_comb begin
    a_d   = a_q;
    tgt_d = tgt_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    sq_d  = sq_q;
    ok_d  = ok_q;
    if (accept) begin
      a_d   = root_abs;
      tgt_d = $unsigned(bus.target);
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      acc_d = acc_sum;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        sq_d = acc_sum;
        ok_d = ok_calc;
      end
    end
  end

  // Datapath registers; reset discards any in-flight result
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      tgt_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      sq_q  <= '0;
      ok_q  <= 1'b0;
    end else begin
      a_q   <= a_d;
      tgt_q <= tgt_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sq_q  <= sq_d;
      ok_q  <= ok_d;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    bus.busy    = (state_q != IDLE);
    bus.valid   = (state_q == DONE);
    bus.square  = sq_q;
    bus.root_ok = ok_q;
  end

endmodule

// File: tb/tb_square_check.sv
// tb/tb_square_check.sv - directed table and sequence bench for square_check
module tb_square_check;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  square_check_if #(.N_BITS(32)) bus();

  square_check #(.N_BITS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [16:0] root;
    logic [31:0] target;
    logic [32:0] sq;
    logic        ok;
  } vec_t;

  vec_t vecs[14];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [16:0] r, input logic [31:0] t, output int lat);
    bus.root   = r;
    bus.target = t;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    lat = 0;
    while (!bus.valid && lat < 40) begin
      chk("busy_during_run", 64'(bus.busy), 64'd1);
      step();
      lat++;
    end
  endtask

  initial begin
    int          lat;
    int          lat2;
    int          valids;
    int          first;
    logic [32:0] hold_sq;
    logic        hold_ok;

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.root   = '0;
    bus.target = '0;
    step();
    step();
    chk("reset_busy",    64'(bus.busy),    64'd0);
    chk("reset_valid",   64'(bus.valid),   64'd0);
    chk("reset_square",  64'(bus.square),  64'd0);
    chk("reset_root_ok", 64'(bus.root_ok), 64'd0);
    rst = 1'b0;
    step();

    vecs[0]  = '{17'd0,      32'd0,          33'd0,          1'b1};
    vecs[1]  = '{17'd1000,   32'd1000000,    33'd1000000,    1'b1};
    vecs[2]  = '{17'd1000,   32'd1002000,    33'd1000000,    1'b1};
    vecs[3]  = '{17'd1000,   32'd1002001,    33'd1000000,    1'b0};
    vecs[4]  = '{17'd1000,   32'd999999,     33'd1000000,    1'b0};
    vecs[5]  = '{17'h1FFFD,  32'd10,         33'd9,          1'b1};
    vecs[6]  = '{17'h10000,  32'h7FFFFFFF,   33'd4294967296, 1'b0};
    vecs[7]  = '{17'd5,      32'hFFFFFFE7,   33'd25,         1'b0};
    vecs[8]  = '{17'd65535,  32'h7FFFFFFF,   33'd4294836225, 1'b0};
    vecs[9]  = '{17'd46340,  32'h7FFFFFFF,   33'd2147395600, 1'b1};
    vecs[10] = '{17'd7,      32'd49,         33'd49,         1'b1};
    vecs[11] = '{17'd7,      32'd63,         33'd49,         1'b1};
    vecs[12] = '{17'd7,      32'd64,         33'd49,         1'b0};
    vecs[13] = '{17'h1FFFF,  32'd1,          33'd1,          1'b1};

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].root, vecs[i].target, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd17);
      chk($sformatf("vec%0d_square", i),  64'(bus.square),  64'(vecs[i].sq));
      chk($sformatf("vec%0d_root_ok", i), 64'(bus.root_ok), 64'(vecs[i].ok));
      chk($sformatf("vec%0d_busy_at_valid", i), 64'(bus.busy), 64'd1);
      step();
      chk($sformatf("vec%0d_valid_drop", i), 64'(bus.valid), 64'd0);
      chk($sformatf("vec%0d_busy_drop", i),  64'(bus.busy),  64'd0);
    end

    // start pulses mid-run are ignored
    bus.root   = 17'd9;
    bus.target = 32'd81;
    bus.start  = 1'b1;
    step();
    valids = 0;
    first  = 0;
    for (int c = 1; c <= 40; c++) begin
      bus.start = (c >= 3 && c <= 10);
      step();
      if (bus.valid) begin
        valids++;
        if (first == 0) first = c;
      end
    end
    bus.start = 1'b0;
    chk("ignore_start_valid_count", 64'(valids), 64'd1);
    chk("ignore_start_latency",     64'(first),  64'd17);
    chk("ignore_start_square",      64'(bus.square), 64'd81);

    // back-to-back accept in the DONE cycle
    run_op(17'd3, 32'd9, lat);
    chk("b2b_first_latency", 64'(lat), 64'd17);
    chk("b2b_first_square",  64'(bus.square), 64'd9);
    bus.root   = 17'd7;
    bus.target = 32'd49;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    chk("b2b_busy_after_accept", 64'(bus.busy), 64'd1);
    lat2 = 0;
    while (!bus.valid && lat2 < 40) begin
      step();
      lat2++;
    end
    chk("b2b_second_latency", 64'(lat2), 64'd17);
    chk("b2b_second_square",  64'(bus.square),  64'd49);
    chk("b2b_second_root_ok", 64'(bus.root_ok), 64'd1);
    step();

    // reset in the middle of a run
    bus.root   = 17'd300;
    bus.target = 32'd90000;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    for (int c = 1; c < 8; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy",    64'(bus.busy),    64'd0);
    chk("midrst_valid",   64'(bus.valid),   64'd0);
    chk("midrst_square",  64'(bus.square),  64'd0);
    chk("midrst_root_ok", 64'(bus.root_ok), 64'd0);
    valids = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (bus.valid) valids++;
    end
    chk("midrst_no_valid", 64'(valids), 64'd0);
    run_op(17'd300, 32'd90000, lat);
    chk("postrst_latency", 64'(lat), 64'd17);
    chk("postrst_square",  64'(bus.square),  64'd90000);
    chk("postrst_root_ok", 64'(bus.root_ok), 64'd1);

    // results hold while inputs wander with no start
    hold_sq = 33'd90000;
    hold_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.root   = 17'($urandom);
      bus.target = $urandom;
      step();
      chk("hold_square",  64'(bus.square),  64'(hold_sq));
      chk("hold_root_ok", 64'(bus.root_ok), 64'(hold_ok));
      chk("hold_valid",   64'(bus.valid),   64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
